axi_rd_slave_mem: RTL and testbench
===================================

Name: axi_rd_slave_mem

Overview:
AXI3 read-channel responder. It implements the slave end of the read address and read data channels and serves bursts from an internal word-addressed memory. One burst is in flight at a time. A simple backdoor write port preloads the memory, so the block serves as the read target for interconnect and master-side benches.

Parameters:
AW, 32, address width
DW, 32, data width (power of 2, ≥8); bytes-per-word BPW = DW/8
DEPTH, 256, memory depth in DW-bit words (power of 2)
BASE, 0, byte base address of the memory window (aligned to DEPTH*BPW)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
ARID  input  4  read ID
ARADDR  input  AW  burst start byte address
ARLEN  input  4  beats minus 1
ARSIZE  input  3  log2 bytes per beat
ARBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ARLOCK/ARCACHE/ARPROT  input  2/4/3  accepted, ignored
ARVALID  input  1  address valid
ARREADY  output  1  address ready
RID  output  4  captured ARID
RDATA  output  DW  read data
RRESP  output  2  00 OKAY, 10 SLVERR, 11 DECERR
RLAST  output  1  final beat
RVALID  output  1  data valid
RREADY  input  1  data ready
bd_we  input  1  backdoor write enable
bd_addr  input  log2(DEPTH)  backdoor word index
bd_wdata  input  DW  backdoor data

Behaviour:
- One clock (clk); reset is synchronous and active-low (rstn).
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, state=IDLE. Memory contents are not reset.
- FSM states: IDLE and BURST.
- IDLE: ARREADY=1 (registered; first high in the cycle after rstn deasserts).
- AR handshake (ARVALID&&ARREADY): capture ID, addr, len, size, burst. Next cycle: ARREADY=0, state=BURST, and beat 0 presented with RVALID=1.
- Read latency is 1 cycle from AR handshake to first RVALID.
- Beat word index = ((addr-BASE)/BPW) mod DEPTH. Data is registered into RDATA when the beat is presented.
- Stall: while RVALID&&!RREADY, RDATA/RRESP/RLAST/RID hold stable.
- Advance: on RVALID&&RREADY, present the next beat in the next cycle. With RREADY held high, there is one beat per cycle.
- RLAST=1 only on beat ARLEN.
- Last beat handshake: next cycle RVALID=0, RLAST=0, state=IDLE, ARREADY=1. There is one dead cycle between bursts.
- Address update per beat:
  - FIXED: unchanged.
  - INCR: first beat uses ARADDR; subsequent beats use (aligned addr)+2^ARSIZE.
  - WRAP: addr+2^ARSIZE, wrapping within a (ARLEN+1)*2^ARSIZE-byte aligned boundary.
- Narrow beats (ARSIZE<log2 BPW) return the full word; the master selects lanes.
- SLVERR for all beats, RDATA=0, if any of:
  - ARSIZE > log2(BPW);
  - ARBURST=11;
  - WRAP with ARLEN not in {1,3,7,15};
  - WRAP with ARADDR not aligned to 2^ARSIZE.
  The full ARLEN+1 beats are still returned.
- DECERR, RDATA=0, evaluated per beat: the beat address is outside [BASE, BASE+DEPTH*BPW). An INCR burst running off the end yields OKAY beats followed by DECERR beats.
- Exclusive (ARLOCK=01): treated as normal; RRESP=OKAY (exclusive failure).
- Backdoor write: mem[bd_addr]<=bd_wdata at clk edge, any state. Same-cycle collision with a beat load of the same word: the beat gets the old value.
- ARVALID while busy: ignored (ARREADY=0); the master holds it.
- Reset mid-burst: burst discarded. In the cycle after rstn deasserts: RVALID=0, RLAST=0, state=IDLE, and ARREADY=1 (it drops to 0 only while rstn is low).

Test Plan:
1. Preload mem[4]=0xDEADBEEF; AR ID=5, addr 0x10, len 0, size 2, INCR -> one beat, 1 cycle after AR handshake: RDATA=0xDEADBEEF, RRESP=00, RLAST=1, RID=5; ARREADY=1 again 1 cycle after the R handshake.
2. Preload mem[0..3]=0,1,2,3; INCR addr 0x0 len 3, RREADY pattern 1,0,0,1,1,0,1 -> beats 0,1,2,3 in order; data/RLAST stable during stalls; RLAST only on beat 3.
3. WRAP addr 0x08 len 3 size 2 -> words 2,3,0,1. WRAP addr 0x08 len 2 -> 3 beats, all SLVERR, RDATA=0.
4. FIXED addr 0x0C len 2 -> mem[3] three times, RLAST on beat 2. ARSIZE=3, len 0 -> one SLVERR beat.
5. INCR addr 0x3F8 len 3 (DEPTH 256, BASE 0) -> RRESP OKAY,OKAY,DECERR,DECERR; RDATA mem[254],mem[255],0,0. AR addr 0x400 len 0 -> one DECERR beat, RDATA=0.
6. Reset pulse at beat 2 of an 8-beat burst -> ARREADY=0 while rstn is low; next cycle RVALID=0 and ARREADY=1; a new 1-beat burst then completes correctly. Backdoor write to mem[1] during beat 0 of a burst reading 0,1 -> beat 1 returns the new value.

Source files
------------

// File: rtl/axi_rd_slave_mem.sv
// AXI3 read-channel slave serving one burst at a time from an internal word memory.
// A backdoor write port preloads the memory; reads follow FIXED/INCR/WRAP addressing.
module axi_rd_slave_mem #(
  parameter int              AW    = 32,
  parameter int              DW    = 32,
  parameter int              DEPTH = 256,
  parameter logic [AW-1:0]   BASE  = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [3:0]               ARID,
  input  logic [AW-1:0]            ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic [1:0]               ARLOCK,
  input  logic [3:0]               ARCACHE,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [3:0]               RID,
  output logic [DW-1:0]            RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     bd_we,
  input  logic [$clog2(DEPTH)-1:0] bd_addr,
  input  logic [DW-1:0]            bd_wdata
);

  localparam int            BPW      = DW / 8;
  localparam int            LB       = $clog2(BPW);
  localparam int            IW       = $clog2(DEPTH);
  localparam logic [AW:0]   WIN      = (AW+1)'(DEPTH * BPW);
  localparam logic [2:0]    MAX_SIZE = 3'(LB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [3:0]      len_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [3:0]      beat_q;
  logic            slverr_q;

  logic [DW-1:0]   mem [DEPTH];

  // Lock, cache and protection attributes have no effect on a plain memory target.
  logic unused_attr;
  assign unused_attr = ^{ARLOCK, ARCACHE, ARPROT};

  // NOTE: the memory array is deliberately left out of reset; clearing it would need
  // a per-word reset fan-out and would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                               input logic [2:0]    sz,
                                               input logic [3:0]    ln,
                                               input logic [1:0]    bt);
    logic [AW-1:0] step;
    logic [AW-1:0] wmask;
    step  = AW'(1) << sz;
    wmask = ((AW'(ln) + AW'(1)) << sz) - AW'(1);
    case (bt)
      BURST_INCR: next_addr = (a & ~(step - AW'(1))) + step;
      BURST_WRAP: next_addr = (a & ~wmask) | ((a + step) & wmask);
      default:    next_addr = a;
    endcase
  endfunction

  logic            ar_err;
  logic            wrap_len_ok;
  logic [AW-1:0]   ld_addr;
  logic            ld_err;
  logic [3:0]      ld_len;
  logic [3:0]      ld_beat;
  logic [AW:0]     ld_off;
  logic [IW-1:0]   ld_idx;
  logic [1:0]      ld_resp;
  logic [DW-1:0]   ld_data;
  logic            ar_hs;
  logic            load;

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wrap_len_ok = ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15};
    ar_err = (ARSIZE > MAX_SIZE) || (ARBURST == BURST_RSVD) ||
             ((ARBURST == BURST_WRAP) &&
              (!wrap_len_ok || ((ARADDR & ((AW'(1) << ARSIZE) - AW'(1))) != '0)));

    ld_addr = ARADDR;
    ld_err  = ar_err;
    ld_len  = ARLEN;
    ld_beat = '0;
    if (state == BURST) begin
      ld_addr = next_addr(addr_q, size_q, len_q, burst_q);
      ld_err  = slverr_q;
      ld_len  = len_q;
      ld_beat = beat_q + 4'd1;
    end

    // Extra MSB catches addresses below BASE: the borrow lands far outside WIN.
    ld_off = {1'b0, ld_addr} - {1'b0, BASE};
    ld_idx = IW'(ld_off >> LB);
    if (ld_err)            ld_resp = RESP_SLVERR;
    else if (ld_off < WIN) ld_resp = RESP_OKAY;
    else                   ld_resp = RESP_DECERR;
    ld_data = (ld_resp == RESP_OKAY) ? mem[ld_idx] : '0;

    ar_hs = (state == IDLE) && ARVALID && ARREADY;
    load  = ar_hs || ((state == BURST) && RVALID && RREADY && !RLAST);
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RLAST    <= 1'b0;
      RID      <= '0;
      RDATA    <= '0;
      RRESP    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
      beat_q   <= '0;
      slverr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ARREADY <= 1'b1;
          if (ar_hs) begin
            ARREADY  <= 1'b0;
            state    <= BURST;
            RID      <= ARID;
            len_q    <= ARLEN;
            size_q   <= ARSIZE;
            burst_q  <= ARBURST;
            slverr_q <= ar_err;
          end
        end
        BURST: begin
          if (RVALID && RREADY && RLAST) begin
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            state   <= IDLE;
            ARREADY <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Beat presentation is shared by the first beat and every subsequent advance.
      if (load) begin
        addr_q <= ld_addr;
        beat_q <= ld_beat;
        RVALID <= 1'b1;
        RLAST  <= (ld_beat == ld_len);
        RDATA  <= ld_data;
        RRESP  <= ld_resp;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Scoreboard bench for axi_rd_slave_mem: directed bursts push expected beats,
// an independent monitor compares every presented beat against the queue head.
module tb_axi_rd_slave_mem;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    ARID;
  logic [AW-1:0] ARADDR;
  logic [3:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic [1:0]    ARLOCK;
  logic [3:0]    ARCACHE;
  logic [2:0]    ARPROT;
  logic          ARVALID;
  logic          ARREADY;
  logic [3:0]    RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;
  logic          bd_we;
  logic [7:0]    bd_addr;
  logic [DW-1:0] bd_wdata;

  always #5 clk = ~clk;

  axi_rd_slave_mem #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE('0)) dut (
    .clk(clk), .rstn(rstn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  typedef struct packed {
    logic [3:0]    id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_beat(input logic [3:0] id, input logic [DW-1:0] data,
                          input logic [1:0] resp, input logic last);
    beat_t b;
    b.id = id; b.data = data; b.resp = resp; b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: every cycle a beat is shown it must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rstn === 1'b1 && RVALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got RID=%0h RDATA=0x%0h, expected no beat", RID, RDATA);
      end else begin
        check("rid",   64'(RID),   64'(exp_q[0].id));
        check("rdata", 64'(RDATA), 64'(exp_q[0].data));
        check("rresp", 64'(RRESP), 64'(exp_q[0].resp));
        check("rlast", 64'(RLAST), 64'(exp_q[0].last));
        if (RREADY) void'(exp_q.pop_front());
      end
    end
  end

  task automatic bd_write(input logic [7:0] idx, input logic [DW-1:0] data);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = idx; bd_wdata = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Returns one step after the AR handshake edge, with beat 0 expected on the bus.
  task automatic send_ar(input logic [3:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [1:0] lock = 2'b00);
    bit got = 1'b0;
    @(posedge clk); #1;
    ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len;
    ARSIZE = size; ARBURST = burst; ARLOCK = lock;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ARREADY) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("arready_timeout", 64'(ARREADY), 64'(1));
      ARVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    check("first_beat_latency", 64'(RVALID), 64'(1));
    check("arready_busy", 64'(ARREADY), 64'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    @(posedge clk); #1;
    check("arready_after_last", 64'(ARREADY), 64'(1));
    check("rvalid_after_last",  64'(RVALID),  64'(0));
    check("rlast_after_last",   64'(RLAST),   64'(0));
  endtask

  task automatic run(input logic [3:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst,
                     input logic [1:0] lock = 2'b00);
    send_ar(id, addr, len, size, burst, lock);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
    ARBURST = '0; ARLOCK = '0; ARCACHE = '0; ARPROT = '0; RREADY = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_arready", 64'(ARREADY), 64'(0));
    check("reset_rvalid",  64'(RVALID),  64'(0));
    check("reset_rlast",   64'(RLAST),   64'(0));
    check("reset_rid",     64'(RID),     64'(0));
    check("reset_rdata",   64'(RDATA),   64'(0));
    check("reset_rresp",   64'(RRESP),   64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    check("arready_after_reset", 64'(ARREADY), 64'(1));

    for (int i = 0; i < 8; i++) bd_write(8'(i), 32'hC0DE_0000 | 32'(i));
    bd_write(8'd4, 32'hDEAD_BEEF);
    bd_write(8'd254, 32'hFEFE_FEFE);
    bd_write(8'd255, 32'hFFFF_0055);

    // Single beat
    exp_beat(4'd5, 32'hDEAD_BEEF, OKAY, 1'b1);
    run(4'd5, 32'h10, 4'd0, 3'd2, INCR);

    // INCR with RREADY stalls
    for (int i = 0; i < 4; i++) exp_beat(4'd1, 32'hC0DE_0000 | 32'(i), OKAY, i == 3);
    RREADY = 1'b1;
    send_ar(4'd1, 32'h0, 4'd3, 3'd2, INCR);
    for (int i = 0; i < 7; i++) begin
      RREADY = pat[i];
      @(posedge clk); #1;
    end
    RREADY = 1'b1;
    wait_done();

    // WRAP 4 beats from word 2
    exp_beat(4'd2, 32'hC0DE_0002, OKAY, 1'b0);
    exp_beat(4'd2, 32'hC0DE_0003, OKAY, 1'b0);
    exp_beat(4'd2, 32'hC0DE_0000, OKAY, 1'b0);
    exp_beat(4'd2, 32'hC0DE_0001, OKAY, 1'b1);
    run(4'd2, 32'h08, 4'd3, 3'd2, WRAP);

    // Narrow WRAP: halfword beats at 6,0,2,4
    exp_beat(4'd6, 32'hC0DE_0001, OKAY, 1'b0);
    exp_beat(4'd6, 32'hC0DE_0000, OKAY, 1'b0);
    exp_beat(4'd6, 32'hC0DE_0000, OKAY, 1'b0);
    exp_beat(4'd6, 32'hC0DE_0001, OKAY, 1'b1);
    run(4'd6, 32'h06, 4'd3, 3'd1, WRAP);

    // Illegal WRAP length, unaligned WRAP, reserved burst
    for (int i = 0; i < 3; i++) exp_beat(4'd3, '0, SLVERR, i == 2);
    run(4'd3, 32'h08, 4'd2, 3'd2, WRAP);
    for (int i = 0; i < 2; i++) exp_beat(4'd4, '0, SLVERR, i == 1);
    run(4'd4, 32'h0A, 4'd1, 3'd2, WRAP);
    for (int i = 0; i < 2; i++) exp_beat(4'd7, '0, SLVERR, i == 1);
    run(4'd7, 32'h00, 4'd1, 3'd2, RSVD);

    // FIXED and oversize beat
    for (int i = 0; i < 3; i++) exp_beat(4'd8, 32'hC0DE_0003, OKAY, i == 2);
    run(4'd8, 32'h0C, 4'd2, 3'd2, FIXED);
    exp_beat(4'd9, '0, SLVERR, 1'b1);
    run(4'd9, 32'h00, 4'd0, 3'd3, INCR);

    // Narrow INCR stays in word 4; exclusive read returns OKAY
    for (int i = 0; i < 3; i++) exp_beat(4'hA, 32'hDEAD_BEEF, OKAY, i == 2);
    run(4'hA, 32'h11, 4'd2, 3'd0, INCR);
    exp_beat(4'hB, 32'hDEAD_BEEF, OKAY, 1'b1);
    run(4'hB, 32'h10, 4'd0, 3'd2, INCR, 2'b01);

    // Running off the end of the window
    exp_beat(4'hC, 32'hFEFE_FEFE, OKAY,   1'b0);
    exp_beat(4'hC, 32'hFFFF_0055, OKAY,   1'b0);
    exp_beat(4'hC, '0,            DECERR, 1'b0);
    exp_beat(4'hC, '0,            DECERR, 1'b1);
    run(4'hC, 32'h3F8, 4'd3, 3'd2, INCR);
    exp_beat(4'hD, '0, DECERR, 1'b1);
    run(4'hD, 32'h400, 4'd0, 3'd2, INCR);

    // Reset during beat 2 of an 8-beat burst
    exp_beat(4'hE, 32'hC0DE_0000, OKAY, 1'b0);
    exp_beat(4'hE, 32'hC0DE_0001, OKAY, 1'b0);
    send_ar(4'hE, 32'h0, 4'd7, 3'd2, INCR);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("beat2_visible", 64'(RVALID), 64'(1));
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midburst_reset_arready", 64'(ARREADY), 64'(0));
    check("midburst_reset_rvalid",  64'(RVALID),  64'(0));
    check("midburst_reset_rlast",   64'(RLAST),   64'(0));
    check("midburst_reset_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    rstn = 1'b1;
    @(posedge clk); #1;
    check("post_reset_rvalid",  64'(RVALID),  64'(0));
    check("post_reset_arready", 64'(ARREADY), 64'(1));
    exp_beat(4'h3, 32'hDEAD_BEEF, OKAY, 1'b1);
    run(4'h3, 32'h10, 4'd0, 3'd2, INCR);

    // Backdoor write while beat 0 stalls: beat 1 sees the new word
    RREADY = 1'b0;
    exp_beat(4'h8, 32'hC0DE_0000, OKAY, 1'b0);
    exp_beat(4'h8, 32'h1111_2222, OKAY, 1'b1);
    send_ar(4'h8, 32'h0, 4'd1, 3'd2, INCR);
    bd_we = 1'b1; bd_addr = 8'd1; bd_wdata = 32'h1111_2222;
    @(posedge clk); #1;
    bd_we = 1'b0;
    RREADY = 1'b1;
    wait_done();

    // Backdoor write on the same edge beat 1 is loaded: beat 1 sees the old word
    exp_beat(4'h9, 32'hC0DE_0000, OKAY, 1'b0);
    exp_beat(4'h9, 32'h1111_2222, OKAY, 1'b1);
    send_ar(4'h9, 32'h0, 4'd1, 3'd2, INCR);
    bd_we = 1'b1; bd_addr = 8'd1; bd_wdata = 32'h3333_4444;
    @(posedge clk); #1;
    bd_we = 1'b0;
    wait_done();
    exp_beat(4'hA, 32'h3333_4444, OKAY, 1'b1);
    run(4'hA, 32'h04, 4'd0, 3'd2, INCR);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
